// File: rtl/fir_output_stage.sv
// Output stage of a FIR filter: decimates, rounds and saturates the full-precision
// sum, then queues samples in a small FIFO with a valid/ready handshake.
module fir_output_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic signed [2*DATA_WIDTH-1:0] filter_in,
   input  logic [3:0]                    decim,
   input  logic                          sat_clr,
   output logic signed [DATA_WIDTH-1:0]  out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          sat_flag,
   output logic [7:0]                    drop_count
);

   localparam int IW = 2 * DATA_WIDTH;
   localparam int SW = IW + 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic signed [SW-1:0] HALF    = SW'(1) << (FRAC_BITS - 1);
   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic [3:0]                   dec_cnt_reg;
   logic [3:0]                   decim_eff;
   logic                         keep;
   logic signed [SW-1:0]         sum_ext;
   logic signed [SW-1:0]         rounded;
   logic                         clip_hi;
   logic                         clip_lo;
   logic signed [DATA_WIDTH-1:0] sat_val;

   logic                         s1_valid_reg;
   logic signed [DATA_WIDTH-1:0] s1_data_reg;
   logic                         sat_flag_reg;
   logic [7:0]                   drop_count_reg;

   logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]                  wr_ptr_reg;
   logic [AW:0]                  rd_ptr_reg;
   logic                         fifo_empty;
   logic                         fifo_full;
   logic                         pop;
   logic                         push;
   logic                         drop;

   assign decim_eff = (decim == 4'd0) ? 4'd1 : decim;
   assign keep      = enable && (dec_cnt_reg == 4'd0);

   // One extra bit of headroom keeps the rounding addition from wrapping.
   assign sum_ext = $signed({filter_in[IW-1], filter_in}) + HALF;
   assign rounded = sum_ext >>> FRAC_BITS;
   assign clip_hi = rounded > SAT_MAX;
   assign clip_lo = rounded < SAT_MIN;
   assign sat_val = clip_hi ? SAT_MAX[DATA_WIDTH-1:0] :
                    clip_lo ? SAT_MIN[DATA_WIDTH-1:0] : rounded[DATA_WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec_cnt_reg  <= '0;
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         sat_flag_reg <= 1'b0;
      end else begin
         if (enable) begin
            if (dec_cnt_reg >= decim_eff - 4'd1)
               dec_cnt_reg <= '0;
            else
               dec_cnt_reg <= dec_cnt_reg + 4'd1;
         end
         s1_valid_reg <= keep;
         if (keep)
            s1_data_reg <= sat_val;
         // Set has priority over a simultaneous clear.
         if (keep && (clip_hi || clip_lo))
            sat_flag_reg <= 1'b1;
         else if (sat_clr)
            sat_flag_reg <= 1'b0;
      end
   end

   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop        = !fifo_empty && out_ready;
   assign push       = s1_valid_reg && (!fifo_full || pop);
   assign drop       = s1_valid_reg && fifo_full && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         drop_count_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (drop && (drop_count_reg != 8'hFF))
            drop_count_reg <= drop_count_reg + 8'd1;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg[AW-1:0]] <= s1_data_reg;
   end

   assign out_valid  = !fifo_empty;
   assign out_data   = out_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;
   assign sat_flag   = sat_flag_reg;
   assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_fir_output_stage.sv
// Randomized and directed bench for fir_output_stage: a queue-based reference model
// predicts delivered samples, drops and the saturation flag; a monitor checks them.
module tb_fir_output_stage;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               enable = 1'b0;
   logic signed [31:0] filter_in = '0;
   logic [3:0]         decim = 4'd1;
   logic               sat_clr = 1'b0;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic               sat_flag;
   logic [7:0]         drop_count;

   int total = 0;
   int bad   = 0;
   int xfers = 0;

   // reference model state
   logic signed [15:0] exp_q[$];
   int                 occ = 0;
   bit                 s1_v = 0;
   logic signed [15:0] s1_d = '0;
   int                 m_cnt = 0;
   bit                 m_sat = 0;
   int                 m_drops = 0;

   fir_output_stage #(.DATA_WIDTH(16), .FRAC_BITS(15), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .filter_in(filter_in),
      .decim(decim), .sat_clr(sat_clr), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .sat_flag(sat_flag), .drop_count(drop_count)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint round_sat(input longint x, output bit clip);
      longint r;
      r = (x + 16384) >>> 15;
      clip = 0;
      if (r > 32767) begin r = 32767; clip = 1; end
      if (r < -32768) begin r = -32768; clip = 1; end
      return r;
   endfunction

   // Reference model: evaluated at each clock edge from the inputs in force.
   initial begin
      bit pop, keep, clip;
      int deff;
      longint r;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            occ = 0; exp_q.delete(); s1_v = 0; m_cnt = 0; m_sat = 0; m_drops = 0;
         end else begin
            pop = (occ > 0) && out_ready;
            if (s1_v) begin
               if (occ == 4 && !pop) begin
                  if (m_drops < 255) m_drops++;
               end else begin
                  exp_q.push_back(s1_d);
                  occ++;
               end
            end
            if (pop) occ--;
            keep = enable && (m_cnt == 0);
            clip = 0;
            if (keep) begin
               r = round_sat(longint'(filter_in), clip);
               s1_d = 16'(r);
            end
            s1_v = keep;
            if (enable) begin
               deff = (decim == 0) ? 1 : int'(decim);
               if (m_cnt >= deff - 1) m_cnt = 0; else m_cnt++;
            end
            if (keep && clip) m_sat = 1;
            else if (sat_clr) m_sat = 0;
         end
      end
   end

   // Monitor: samples away from the active edge and pops the scoreboard on transfers.
   initial begin
      bit hold_v = 0;
      logic signed [15:0] hold_d = '0;
      logic signed [15:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("valid_in_reset", out_valid, 0);
            hold_v = 0;
         end else begin
            check("out_valid", out_valid, occ > 0);
            if (!out_valid) check("idle_data_zero", out_data, 0);
            if (hold_v) check("data_stable", out_data, hold_d);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  xfers++;
                  $display("xfer %0d data=%0d exp=%0d", xfers, out_data, e);
                  check("out_data", out_data, e);
               end
            end
            check("sat_flag", sat_flag, m_sat);
            check("drop_count", drop_count, m_drops);
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
         end
      end
   end

   task automatic step(input bit en, input longint x);
      enable = en;
      filter_in = 32'(x);
      @(posedge clk);
      #2;
      enable = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0);
   endtask

   // Asserted mid-cycle: outputs must clear without a clock edge.
   task automatic do_reset();
      #1 reset = 1'b1;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_sat", sat_flag, 0);
      check("rst_drops", drop_count, 0);
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      int base;
      #1 reset = 1'b1;
      @(posedge clk);
      #2;
      check("init_valid", out_valid, 0);
      check("init_data", out_data, 0);
      check("init_drops", drop_count, 0);
      reset = 1'b0;

      // rounding
      out_ready = 1'b1; decim = 4'd1;
      step(1, 49152); step(1, 16384); step(1, -16384); step(1, -16385);
      idle(4);
      check("round_sat_flag", sat_flag, 0);
      check("round_count", xfers, 4);

      // saturation and flag clear
      step(1, 64'sh4000_0000); step(1, -64'sh4000_0000);
      idle(3);
      check("sat_set", sat_flag, 1);
      sat_clr = 1'b1; step(0, 0); sat_clr = 1'b0;
      check("sat_cleared", sat_flag, 0);

      // decimation by 3
      decim = 4'd3; base = xfers;
      for (int k = 1; k <= 9; k++) step(1, k * 32768);
      idle(4);
      check("decim_outputs", xfers - base, 3);

      // backpressure with drops, then full FIFO with simultaneous pop
      do_reset();
      decim = 4'd1; out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) step(1, k * 32768);
      idle(3);
      check("bp_drops", drop_count, 2);
      check("bp_head", out_data, 1);
      check("bp_valid", out_valid, 1);
      step(1, 7 * 32768);
      out_ready = 1'b1;
      step(0, 0);
      idle(6);
      check("full_pop_drops", drop_count, 2);
      check("drained_valid", out_valid, 0);

      // reset with entries queued and one sample in stage 1
      do_reset();
      out_ready = 1'b0;
      for (int k = 10; k <= 13; k++) step(1, k * 32768);
      do_reset();
      decim = 4'd2; out_ready = 1'b1; base = xfers;
      step(1, 20 * 32768); step(1, 21 * 32768);
      idle(3);
      check("post_reset_outputs", xfers - base, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) decim = 4'($urandom_range(0, 4));
         out_ready = ($urandom_range(0, 9) < 6);
         sat_clr   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 1) == 0)
            step($urandom_range(0, 9) < 7, longint'($signed($urandom())));
         else
            step($urandom_range(0, 9) < 7, longint'($urandom_range(0, 2097152)) - 1048576);
      end
      sat_clr = 1'b0;

      // drain with a bounded wait
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (out_valid || exp_q.size() != 0 || s1_v); i++) step(0, 0);
      check("drain_empty", exp_q.size(), 0);
      check("drain_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
